// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    localparam int INSTR_W = 32;
    typedef enum logic [1:0] {IDLE, FETCH, DATA} arb_state_t;
    typedef enum logic {G_FETCH, G_DATA} grant_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    import mem_arb_pkg::*;
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               flush;
    logic [INSTR_W-1:0] if_rdata;
    logic               if_done;
    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic [DATA_W-1:0]  d_rdata;
    logic               d_done;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ack;
    logic               stall_if;
    logic               stall_mem;
    modport slave (
        input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
    modport master (
        output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-requester round-robin picker, favouring the port not granted last
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   req_f,
    input  logic   req_d,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant
);
    assign grant_valid = req_f | req_d;
    assign grant = (req_f & req_d) ? ((last_grant == G_DATA) ? G_FETCH : G_DATA)
                                   : (req_d ? G_DATA : G_FETCH);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic clk,
    input logic reset_n,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        state, state_nxt;
    grant_t            last_grant, grant;
    logic              grant_valid, drop, we_q, req_f, req_d, drop_now;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // a port is not regranted in its own done cycle; flush blocks a fetch grant
    assign req_f = bus.if_req & ~bus.flush & ~bus.if_done;
    assign req_d = bus.d_req & ~bus.d_done;
    assign drop_now = drop | bus.flush;

    mem_arb_pick u_pick (
        .req_f      (req_f),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next state: grant from IDLE, return to IDLE on ack (ack in IDLE is stale)
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = grant_valid ? ((grant == G_DATA) ? DATA : FETCH) : IDLE;
        else if (bus.mem_ack) state_nxt = IDLE;
    end

    // grant latches, fetch drop flag and registered responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant   <= G_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            drop         <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.d_done   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;
            drop        <= (state == FETCH) & ~bus.mem_ack & drop_now;
            if (state == IDLE && grant_valid) begin
                last_grant <= grant;
                addr_q     <= (grant == G_DATA) ? bus.d_addr : bus.if_addr;
                we_q       <= (grant == G_DATA) & bus.d_we;
                if (grant == G_DATA) wdata_q <= bus.d_wdata;
            end
            if (state == FETCH && bus.mem_ack && !drop_now) begin
                bus.if_done  <= 1'b1;
                bus.if_rdata <= addr_q[2] ? bus.mem_rdata[2*INSTR_W-1:INSTR_W] : bus.mem_rdata[INSTR_W-1:0];
            end
            if (state == DATA && bus.mem_ack) begin
                bus.d_done <= 1'b1;
                if (!we_q) bus.d_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_we    = we_q & bus.mem_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.d_req & ~bus.d_done;
endmodule
